// File: rtl/mips_alu_pkg.sv
// Shared definitions for the sequential MIPS ALU: func codes, FSM states, flag bundle.
package mips_alu_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [5:0] FUNC_ADD  = 6'b100000;
    localparam logic [5:0] FUNC_ADDU = 6'b100001;
    localparam logic [5:0] FUNC_SUB  = 6'b100010;
    localparam logic [5:0] FUNC_AND  = 6'b100100;
    localparam logic [5:0] FUNC_OR   = 6'b100101;
    localparam logic [5:0] FUNC_NOR  = 6'b100111;
    localparam logic [5:0] FUNC_SLT  = 6'b101010;
    localparam logic [5:0] FUNC_SLTU = 6'b101011;
    localparam logic [5:0] FUNC_CLO  = 6'b111000;
    localparam logic [5:0] FUNC_CLZ  = 6'b000111;
    localparam logic [5:0] FUNC_BGTZ = 6'b110010;
    localparam logic [5:0] FUNC_B    = 6'b110100;
    localparam logic [5:0] FUNC_BLEZ = 6'b110110;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } fsmState_t;

    typedef struct packed {
        logic overflow;
        logic condTrue;
        logic illegal;
    } aluFlags_t;

endpackage

// File: rtl/lead_counter.sv
// Iterative leading-ones/zeros scanner; the MSB is checked at load time by the
// caller, so the first scan cycle already looks at the second bit.
module lead_counter
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
    input  logic             countOnes,
    input  logic [WIDTH-1:0] data,
    output logic             firstMatch,
    output logic             finish,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] shReg;
    logic [CW-1:0]    cnt;
    logic             matchBit;
    logic             hit;
    logic [CW-1:0]    nextCnt;

    assign firstMatch = (data[WIDTH-1] == countOnes);
    assign hit        = (shReg[WIDTH-1] == matchBit);
    assign nextCnt    = cnt + CW'(hit);
    // Stop on the first mismatch, or once every bit has matched.
    assign finish     = run && (!hit || (nextCnt == CW'(WIDTH)));
    assign count      = nextCnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shReg    <= '0;
            cnt      <= '0;
            matchBit <= 1'b0;
        end else if (load) begin
            shReg    <= data << 1;
            cnt      <= CW'(1);
            matchBit <= countOnes;
        end else if (run) begin
            shReg    <= shReg << 1;
            cnt      <= nextCnt;
        end
    end

endmodule

// File: rtl/mips_alu_seq.sv
// MIPS ALU with registered outputs; single-cycle ops complete in one cycle,
// CLO/CLZ iterate one bit per cycle through lead_counter.
module mips_alu_seq
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             condTrue,
    output logic             illegal
);
    localparam int CW = $clog2(WIDTH + 1);

    fsmState_t        state, stateNext;
    aluFlags_t        aluFlags, flagsQ, flagsNext;
    logic [WIDTH-1:0] aluResult, resultNext, sum, diff;
    logic             isCount, goCount, countOnes, doneNext;
    logic             firstMatch, cntFinish;
    logic [CW-1:0]    cntValue;

    always_comb begin
        sum       = opA + opB;
        diff      = opA - opB;
        aluResult = '0;
        aluFlags  = '0;
        isCount   = 1'b0;
        case (func)
            FUNC_ADD: begin
                aluResult         = sum;
                aluFlags.overflow = (opA[WIDTH-1] == opB[WIDTH-1]) && (sum[WIDTH-1] != opA[WIDTH-1]);
            end
            FUNC_ADDU: aluResult = sum;
            FUNC_SUB: begin
                aluResult         = diff;
                aluFlags.overflow = (opA[WIDTH-1] != opB[WIDTH-1]) && (diff[WIDTH-1] != opA[WIDTH-1]);
            end
            FUNC_AND:  aluResult = opA & opB;
            FUNC_OR:   aluResult = opA | opB;
            FUNC_NOR:  aluResult = ~(opA | opB);
            FUNC_SLT:  aluResult[0] = $signed(opA) < $signed(opB);
            FUNC_SLTU: aluResult[0] = opA < opB;
            FUNC_BGTZ: begin
                aluResult         = opA;
                aluFlags.condTrue = !opA[WIDTH-1] && (opA != '0);
            end
            FUNC_BLEZ: begin
                aluResult         = opA;
                aluFlags.condTrue = opA[WIDTH-1] || (opA == '0);
            end
            FUNC_B: begin
                aluResult         = opA;
                aluFlags.condTrue = 1'b1;
            end
            FUNC_CLO, FUNC_CLZ: begin
                isCount      = 1'b1;
                // Only reaches the output when no iteration is needed (k=0, or WIDTH=1).
                aluResult[0] = firstMatch;
            end
            default: aluFlags.illegal = 1'b1;
        endcase
    end

    assign countOnes = (func == FUNC_CLO);
    assign goCount   = isCount && firstMatch && (WIDTH > 1);

    lead_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) uLeadCounter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (start && (state == IDLE) && goCount),
        .run        (state == COUNT),
        .countOnes  (countOnes),
        .data       (opA),
        .firstMatch (firstMatch),
        .finish     (cntFinish),
        .count      (cntValue)
    );

    always_comb begin
        stateNext  = state;
        doneNext   = 1'b0;
        resultNext = result;
        flagsNext  = flagsQ;
        case (state)
            IDLE: begin
                if (start) begin
                    if (goCount) begin
                        stateNext = COUNT;
                    end else begin
                        doneNext   = 1'b1;
                        resultNext = aluResult;
                        flagsNext  = aluFlags;
                    end
                end
            end
            COUNT: begin
                if (cntFinish) begin
                    stateNext              = IDLE;
                    doneNext               = 1'b1;
                    resultNext             = '0;
                    resultNext[CW-1:0]     = cntValue;
                    flagsNext              = '0;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            done   <= 1'b0;
            result <= '0;
            flagsQ <= '0;
        end else begin
            state  <= stateNext;
            done   <= doneNext;
            result <= resultNext;
            flagsQ <= flagsNext;
        end
    end

    assign busy     = (state == COUNT);
    assign zero     = (result == '0);
    assign overflow = flagsQ.overflow;
    assign condTrue = flagsQ.condTrue;
    assign illegal  = flagsQ.illegal;

endmodule

// File: doc/mips_alu_seq.md
MIPS_ALU_SEQ -- requirements
Module: mips_alu_seq

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, datapath width in bits.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: start  input  1  request; accepted only when busy=0.
REQ-005 SHALL have port: func  input  6  operation code from the ALU control stage, sampled with start.
REQ-006 SHALL have port: opA  input  WIDTH  first operand, sampled with start.
REQ-007 SHALL have port: opB  input  WIDTH  second operand, sampled with start.
REQ-008 SHALL have port: busy  output  1  high while a multi-cycle count is in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; result and flags valid.
REQ-010 SHALL have port: result  output  WIDTH  registered result.
REQ-011 SHALL have port: zero  output  1  result == 0.
REQ-012 SHALL have port: overflow  output  1  signed overflow of add/sub.
REQ-013 SHALL have port: condTrue  output  1  branch condition outcome.
REQ-014 SHALL have port: illegal  output  1  func not in supported set.

Function
REQ-015 SHALL support func codes: 100000 add (signed), 100001 addu, 100010 sub (signed), 100100 and, 100101 or, 100111 nor, 101010 slt, 101011 sltu, 111000 CLO, 000111 CLZ, 110010 BGTZ, 110100 B, 110110 BLEZ.
REQ-016 SHALL use states IDLE and COUNT; IDLE->COUNT only on accepted CLO/CLZ; COUNT->IDLE on count completion.
REQ-017 Single-cycle ops SHALL register result/flags and pulse done on the first rising edge after the start-accept edge (latency 1), FSM remaining in IDLE.
REQ-018 add/sub SHALL produce wrapped WIDTH-bit result and set overflow per signed rule; all other ops SHALL clear overflow.
REQ-019 slt/sltu SHALL yield 1 or 0 zero-extended to WIDTH.
REQ-020 BGTZ: condTrue = (signed opA > 0); BLEZ: condTrue = (signed opA <= 0); B: condTrue = 1; result = opA; all non-branch ops SHALL clear condTrue.
REQ-021 CLO/CLZ SHALL scan opA from MSB, one bit per cycle, counting consecutive 1s (CLO) or 0s (CLZ), stopping at first mismatch.
REQ-022 CLO/CLZ with k leading matches SHALL pulse done k+1 cycles after accept for k<WIDTH, and WIDTH cycles after accept for k=WIDTH; result = k.
REQ-023 busy SHALL be 1 exactly while state=COUNT; done cycle SHALL have busy=0.
REQ-024 start while busy=1 SHALL be ignored without side effect.
REQ-025 start in the same cycle as done SHALL be accepted.
REQ-026 Unsupported func SHALL set illegal=1, result=0, other flags 0, done after 1 cycle; supported ops SHALL clear illegal.
REQ-027 result and flags SHALL hold until the next done; done SHALL never assert for two consecutive cycles of a single operation.
REQ-028 zero SHALL be computed from the registered result value.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force state=IDLE, busy=0, done=0, result=0, zero=1, overflow=0, condTrue=0, illegal=0.
REQ-030 Reset mid-COUNT SHALL abort the operation with no done pulse; reset SHALL win over simultaneous start.

Structure
REQ-031 Func code constants, state enum and WIDTH default SHALL live in shared package mips_alu_pkg.
REQ-032 The iterative CLO/CLZ counter (shift register, counter, match bit, finish strobe) SHALL be sub-module lead_counter.

Verification
REQ-033 add 0x7FFFFFFF + 0x00000001 -> done after 1 cycle, result 0x80000000, overflow=1; addu same operands -> overflow=0.
REQ-034 CLZ opA=0x00010000 -> busy for 15 cycles, done 16 cycles after accept, result 15; CLZ opA=0 -> result 32, done after 32 cycles.
REQ-035 CLO opA=0xFFFFFFFF -> result 32; start asserted mid-count with func=add -> ignored, no extra done.
REQ-036 BGTZ opA=0 -> condTrue=0; BLEZ opA=0xFFFFFFFF -> condTrue=1; B -> condTrue=1; sub 5-5 -> zero=1.
REQ-037 rst_n low at cycle 5 of CLO opA=0xFFFF0000 -> no done, all outputs at reset values, next start add 2+3 -> result 5.
REQ-038 func=111111 -> illegal=1, result=0, done after 1 cycle; back-to-back start on done cycle -> accepted.
